// File: rtl/kiwi_wf_cic_mc.sv
// Multi-lane runtime-configurable CIC decimator for the waterfall path.
// Shared decimation counter, per-lane pipelined integrator/comb chains, shift+saturate, output FIFO.
module kiwi_wf_cic_mc #(
  parameter int CHANNELS    = 2,
  parameter int STAGES      = 5,
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int DEC_WIDTH   = 13,
  parameter int SHIFT_WIDTH = 7,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                aclk,
  input  logic                                areset,
  output logic                                s_axis_data_tready,
  input  logic [CHANNELS*IN_WIDTH-1:0]        s_axis_data_tdata,
  input  logic                                s_axis_data_tvalid,
  output logic                                s_axis_config_tready,
  input  logic [DEC_WIDTH+SHIFT_WIDTH-1:0]    s_axis_config_tdata,
  input  logic                                s_axis_config_tvalid,
  output logic [CHANNELS*OUT_WIDTH-1:0]       m_axis_data_tdata,
  output logic                                m_axis_data_tvalid,
  input  logic                                m_axis_data_tready,
  output logic                                overflow
);

  localparam int W  = IN_WIDTH + STAGES * DEC_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = CHANNELS * OUT_WIDTH;
  localparam logic [DEC_WIDTH-1:0]   R_RESET = DEC_WIDTH'(32);
  localparam logic [SHIFT_WIDTH-1:0] S_RESET = SHIFT_WIDTH'(STAGES * 5);
  localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  assign s_axis_data_tready   = 1'b1;
  assign s_axis_config_tready = 1'b1;

  logic                   cfg_beat;
  logic                   data_beat;
  logic [DEC_WIDTH-1:0]   cfg_dec;
  logic [DEC_WIDTH-1:0]   cfg_dec_clamped;
  logic [DEC_WIDTH-1:0]   dec_reg;
  logic [SHIFT_WIDTH-1:0] shift_reg;
  logic [DEC_WIDTH-1:0]   cnt_reg;
  logic                   dec_strobe;
  logic                   pipe_clear;

  // A config beat wins over a coincident data beat.
  assign cfg_beat        = s_axis_config_tvalid;
  assign data_beat       = s_axis_data_tvalid && !s_axis_config_tvalid;
  assign pipe_clear      = areset || cfg_beat;
  assign cfg_dec         = s_axis_config_tdata[DEC_WIDTH-1:0];
  assign cfg_dec_clamped = (cfg_dec < DEC_WIDTH'(2)) ? DEC_WIDTH'(2) : cfg_dec;
  assign dec_strobe      = data_beat && (cnt_reg == dec_reg - DEC_WIDTH'(1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      dec_reg   <= R_RESET;
      shift_reg <= S_RESET;
      cnt_reg   <= '0;
    end else if (cfg_beat) begin
      dec_reg   <= cfg_dec_clamped;
      shift_reg <= s_axis_config_tdata[DEC_WIDTH +: SHIFT_WIDTH];
      cnt_reg   <= '0;
    end else if (data_beat) begin
      cnt_reg <= dec_strobe ? '0 : cnt_reg + DEC_WIDTH'(1);
    end
  end

  // integ_en[i]: integrator stage i takes a new sample this cycle.
  logic [STAGES-1:0] beat_pipe_reg;
  logic [STAGES-1:0] integ_en;
  logic [2*STAGES:0] stb_pipe_reg;

  always_comb begin
    integ_en    = beat_pipe_reg << 1;
    integ_en[0] = data_beat;
  end

  always_ff @(posedge aclk) begin
    if (pipe_clear) begin
      beat_pipe_reg <= '0;
      stb_pipe_reg  <= '0;
    end else begin
      beat_pipe_reg <= integ_en;
      stb_pipe_reg  <= {stb_pipe_reg[2*STAGES-1:0], dec_strobe};
    end
  end

  logic [OW-1:0] sat_word;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic        [IN_WIDTH-1:0]  lane_raw;
    logic signed [W-1:0]         lane_in;
    logic signed [W-1:0]         integ_reg    [STAGES];
    logic signed [W-1:0]         comb_reg     [STAGES];
    logic signed [W-1:0]         comb_dly_reg [STAGES];
    logic signed [W-1:0]         shifted;
    logic signed [OUT_WIDTH-1:0] sat_next;
    logic signed [OUT_WIDTH-1:0] sat_reg;

    assign lane_raw = s_axis_data_tdata[gi*IN_WIDTH +: IN_WIDTH];
    assign lane_in  = {{(W-IN_WIDTH){lane_raw[IN_WIDTH-1]}}, lane_raw};

    always_ff @(posedge aclk) begin
      if (pipe_clear) begin
        for (int i = 0; i < STAGES; i++) integ_reg[i] <= '0;
      end else begin
        if (integ_en[0]) integ_reg[0] <= integ_reg[0] + lane_in;
        for (int i = 1; i < STAGES; i++) begin
          if (integ_en[i]) integ_reg[i] <= integ_reg[i] + integ_reg[i-1];
        end
      end
    end

    // Comb stage j fires when the decimate strobe reaches it.
    always_ff @(posedge aclk) begin
      if (pipe_clear) begin
        for (int j = 0; j < STAGES; j++) begin
          comb_reg[j]     <= '0;
          comb_dly_reg[j] <= '0;
        end
      end else begin
        if (stb_pipe_reg[STAGES-1]) begin
          comb_reg[0]     <= integ_reg[STAGES-1] - comb_dly_reg[0];
          comb_dly_reg[0] <= integ_reg[STAGES-1];
        end
        for (int j = 1; j < STAGES; j++) begin
          if (stb_pipe_reg[STAGES-1+j]) begin
            comb_reg[j]     <= comb_reg[j-1] - comb_dly_reg[j];
            comb_dly_reg[j] <= comb_reg[j-1];
          end
        end
      end
    end

    assign shifted = comb_reg[STAGES-1] >>> shift_reg;

    always_comb begin
      sat_next = shifted[OUT_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
        sat_next = SAT_MAX[OUT_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
        sat_next = SAT_MIN[OUT_WIDTH-1:0];
      end
    end

    always_ff @(posedge aclk) begin
      if (pipe_clear) begin
        sat_reg <= '0;
      end else if (stb_pipe_reg[2*STAGES-1]) begin
        sat_reg <= sat_next;
      end
    end

    assign sat_word[gi*OUT_WIDTH +: OUT_WIDTH] = sat_reg;
  end

  logic [OW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [OW-1:0] head_reg;
  logic          overflow_reg;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign push_req = stb_pipe_reg[2*STAGES];
  assign pop      = m_axis_data_tvalid && m_axis_data_tready;
  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge aclk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= sat_word;
  end

  // head_reg always mirrors the oldest entry so tdata comes straight from a register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (pop) begin
        if (count_reg > (AW+1)'(1)) begin
          head_reg <= fifo_mem[rd_ptr_reg + AW'(1)];
        end else if (push_ok) begin
          head_reg <= sat_word;
        end
      end else if (count_reg == '0 && push_ok) begin
        head_reg <= sat_word;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset || cfg_beat) begin
      overflow_reg <= 1'b0;
    end else if (push_req && full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign m_axis_data_tdata  = head_reg;
  assign m_axis_data_tvalid = (count_reg != '0);
  assign overflow           = overflow_reg;

endmodule
